// File: rtl/enemy_wave_ctrl.sv
// rtl/enemy_wave_ctrl.sv - enemy wave scheduler: staggered slot spawn, kill tracking, level progression
module enemy_wave_ctrl #(
    parameter int N_SLOTS   = 8,
    parameter int COLS      = 4,
    parameter int X0        = 40,
    parameter int Y0        = 20,
    parameter int X_STEP    = 60,
    parameter int Y_STEP    = 50,
    parameter int HP_BASE   = 3,
    parameter int SPAWN_GAP = 2000000,
    parameter int PAUSE     = 50000000,
    parameter int MAX_LEVEL = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N_SLOTS-1:0]     enemy_dead,
    output logic [N_SLOTS-1:0]     initialize,
    output logic [20*N_SLOTS-1:0]  slot_pos,
    output logic [9:0]             init_hp,
    output logic [9:0]             level,
    output logic [4:0]             alive_count,
    output logic                   wave_clear,
    output logic                   game_won,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ACTIVE,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [23:0] GAP_RELOAD   = 24'(SPAWN_GAP - 1);
    localparam logic [26:0] PAUSE_RELOAD = 27'(PAUSE - 1);
    localparam logic [4:0]  SLOT_END     = 5'(N_SLOTS);
    localparam logic [9:0]  MAX_LVL      = 10'(MAX_LEVEL);

    function automatic logic [9:0] hp_for(input logic [9:0] lvl);
        int sum;
        sum = HP_BASE + int'(lvl) - 1;
        hp_for = (sum > 1023) ? 10'd1023 : sum[9:0];
    endfunction

    state_t               state_q, state_d;
    logic [N_SLOTS-1:0]   init_q, init_d;
    logic [4:0]           idx_q, idx_d;
    logic [23:0]          gap_q, gap_d;
    logic [26:0]          pause_q, pause_d;
    logic [9:0]           level_q, level_d;
    logic [9:0]           hp_q, hp_d;
    logic                 wave_clear_q, wave_clear_d;
    logic                 game_won_q, game_won_d;
    logic                 busy_q, busy_d;
    logic [4:0]           alive_n;

    // Formation positions are fixed by parameters, so they are pure wiring.
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_pos
        localparam int         PX   = X0 + (i % COLS) * X_STEP;
        localparam int         PY   = Y0 + (i / COLS) * Y_STEP;
        localparam logic [9:0] PX10 = PX[9:0];
        localparam logic [9:0] PY10 = PY[9:0];
        assign slot_pos[20*i +: 20] = {PX10, PY10};
    end

    always_comb begin
        alive_n = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            alive_n = alive_n + 5'(init_q[i] & ~enemy_dead[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        init_d       = init_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        pause_d      = pause_q;
        level_d      = level_q;
        hp_d         = hp_q;
        wave_clear_d = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            init_d  = '0;
            idx_d   = '0;
            gap_d   = '0;
            pause_d = '0;
            level_d = 10'd1;
            hp_d    = hp_for(10'd1);
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_SPAWN;
                        init_d  = '0;
                        idx_d   = '0;
                        gap_d   = '0;
                        level_d = 10'd1;
                        hp_d    = hp_for(10'd1);
                    end
                end
                S_SPAWN: begin
                    // Kills are deliberately not examined here; every slot spawns first.
                    if (idx_q == SLOT_END) begin
                        state_d = S_ACTIVE;
                    end else if (gap_q == '0) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (idx_q == 5'(i)) begin
                                init_d[i] = 1'b1;
                            end
                        end
                        idx_d = idx_q + 5'd1;
                        gap_d = GAP_RELOAD;
                    end else begin
                        gap_d = gap_q - 24'd1;
                    end
                end
                S_ACTIVE: begin
                    if (alive_n == '0) begin
                        state_d      = S_CLEAR;
                        wave_clear_d = 1'b1;
                        init_d       = '0;
                        pause_d      = PAUSE_RELOAD;
                    end
                end
                S_CLEAR: begin
                    if (pause_q == '0) begin
                        if (level_q == MAX_LVL) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SPAWN;
                            level_d = level_q + 10'd1;
                            hp_d    = hp_for(level_q + 10'd1);
                            idx_d   = '0;
                            gap_d   = '0;
                        end
                    end else begin
                        pause_d = pause_q - 27'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    init_d  = '0;
                end
            endcase
        end
        game_won_d = (state_d == S_DONE);
        busy_d     = (state_d == S_SPAWN) || (state_d == S_ACTIVE) || (state_d == S_CLEAR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            init_q       <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            pause_q      <= '0;
            level_q      <= 10'd1;
            hp_q         <= hp_for(10'd1);
            wave_clear_q <= 1'b0;
            game_won_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            pause_q      <= pause_d;
            level_q      <= level_d;
            hp_q         <= hp_d;
            wave_clear_q <= wave_clear_d;
            game_won_q   <= game_won_d;
            busy_q       <= busy_d;
        end
    end

    assign initialize  = init_q;
    assign init_hp     = hp_q;
    assign level       = level_q;
    assign alive_count = alive_n;
    assign wave_clear  = wave_clear_q;
    assign game_won    = game_won_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// tb/tb_enemy_wave_ctrl.sv - self-checking bench for enemy_wave_ctrl
module tb_enemy_wave_ctrl;

    localparam int N   = 8;
    localparam int COLS = 4;
    localparam int X0  = 40;
    localparam int Y0  = 20;
    localparam int XS  = 60;
    localparam int YS  = 50;
    localparam int HPB = 3;
    localparam int G   = 4;
    localparam int P   = 6;
    localparam int ML  = 2;
    localparam int T_ACTIVE = (N - 1) * G + 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [N-1:0]    enemy_dead = '0;
    logic [N-1:0]    initialize;
    logic [20*N-1:0] slot_pos;
    logic [9:0]      init_hp;
    logic [9:0]      level;
    logic [4:0]      alive_count;
    logic            wave_clear;
    logic            game_won;
    logic            busy;

    int              vectors = 0;
    int              miscompares = 0;
    logic [N-1:0]    kills = '0;

    enemy_wave_ctrl #(
        .N_SLOTS(N), .COLS(COLS), .X0(X0), .Y0(Y0), .X_STEP(XS), .Y_STEP(YS),
        .HP_BASE(HPB), .SPAWN_GAP(G), .PAUSE(P), .MAX_LEVEL(ML)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .enemy_dead(enemy_dead),
        .initialize(initialize),
        .slot_pos(slot_pos),
        .init_hp(init_hp),
        .level(level),
        .alive_count(alive_count),
        .wave_clear(wave_clear),
        .game_won(game_won),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Slot k is live once k*G+1 edges have passed since SPAWN entry.
    function automatic logic [N-1:0] spawn_mask(input int t);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (k * G + 1 <= t) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int hp_for(input int lvl);
        int s;
        s = HPB + lvl - 1;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        start = 1'b1;
        edge_step();
        start = 1'b0;
    endtask

    task automatic spawn_phase(input int lvl, input int t_end, input int force_at, input bit rand_kill);
        logic [N-1:0] m;
        logic [N-1:0] prev;
        int k;
        chk("spawn_t0_init", 32'(initialize), 32'd0);
        chk("spawn_t0_busy", 32'(busy), 32'd1);
        chk("spawn_t0_level", 32'(level), 32'(lvl));
        chk("spawn_t0_hp", 32'(init_hp), 32'(hp_for(lvl)));
        for (int t = 1; t <= t_end; t++) begin
            m    = spawn_mask(t);
            prev = spawn_mask(t - 1);
            if (force_at != 0 && t >= force_at) begin
                kills = '1;
            end else if (rand_kill && $urandom_range(3) == 0) begin
                k = int'($urandom_range(N - 1));
                if (prev[k]) kills[k] = 1'b1;
            end
            enemy_dead = kills | (N'($urandom) & ~m);
            edge_step();
            chk("spawn_init", 32'(initialize), 32'(m));
            chk("spawn_alive", 32'(alive_count), 32'($countones(m & ~enemy_dead)));
            chk("spawn_wave_clear", 32'(wave_clear), 32'd0);
            chk("spawn_busy", 32'(busy), 32'd1);
            chk("spawn_level", 32'(level), 32'(lvl));
            chk("spawn_hp", 32'(init_hp), 32'(hp_for(lvl)));
        end
        enemy_dead = kills;
    endtask

    task automatic active_phase();
        int  guard;
        int  k;
        bit  done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 300) begin
            guard++;
            chk("active_alive", 32'(alive_count), 32'($countones(~kills)));
            chk("active_wave_clear", 32'(wave_clear), 32'd0);
            if (kills == '1) begin
                done = 1'b1;
            end else begin
                if ($urandom_range(1) == 1) begin
                    k = int'($urandom_range(N - 1));
                    while (kills[k]) k = (k + 1) % N;
                    kills[k]   = 1'b1;
                    enemy_dead = kills;
                    #1;
                    chk("active_alive_step", 32'(alive_count), 32'($countones(~kills)));
                end
                if (kills == '1) done = 1'b1;
                else edge_step();
            end
        end
        if (!done) chk("active_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_phase(input int lvl, input bit last);
        edge_step();
        chk("clear_pulse", 32'(wave_clear), 32'd1);
        chk("clear_init", 32'(initialize), 32'd0);
        chk("clear_alive", 32'(alive_count), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        kills      = '0;
        enemy_dead = '0;
        for (int i = 1; i < P; i++) begin
            edge_step();
            chk("pause_wave_clear", 32'(wave_clear), 32'd0);
            chk("pause_init", 32'(initialize), 32'd0);
            chk("pause_level", 32'(level), 32'(lvl));
            chk("pause_busy", 32'(busy), 32'd1);
        end
        edge_step();
        if (last) begin
            chk("done_game_won", 32'(game_won), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_init", 32'(initialize), 32'd0);
            chk("done_level", 32'(level), 32'(lvl));
        end
    endtask

    initial begin
        enemy_dead = N'($urandom);
        #12;
        chk("rst_init", 32'(initialize), 32'd0);
        chk("rst_level", 32'(level), 32'd1);
        chk("rst_hp", 32'(init_hp), 32'(HPB));
        chk("rst_wave_clear", 32'(wave_clear), 32'd0);
        chk("rst_game_won", 32'(game_won), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alive", 32'(alive_count), 32'd0);
        for (int i = 0; i < N; i++) begin
            chk("slot_pos", 32'(slot_pos[20*i +: 20]),
                32'({10'(X0 + (i % COLS) * XS), 10'(Y0 + (i / COLS) * YS)}));
        end
        chk("slot5_pos", 32'(slot_pos[100 +: 20]), 32'({10'd100, 10'd70}));
        reset = 1'b1;
        enemy_dead = '0;
        edge_step();
        chk("idle_busy", 32'(busy), 32'd0);

        start_game();
        spawn_phase(1, T_ACTIVE, 10, 1'b0);
        active_phase();
        clear_phase(1, 1'b0);

        spawn_phase(2, T_ACTIVE, 0, 1'b1);
        active_phase();
        clear_phase(2, 1'b1);

        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("done_hold", 32'(game_won), 32'd1);
        end

        start = 1'b1;
        edge_step();
        spawn_phase(1, T_ACTIVE, 0, 1'b0);
        start = 1'b0;
        chk("restart_game_won", 32'(game_won), 32'd0);
        active_phase();
        clear_phase(1, 1'b0);

        spawn_phase(2, 3 * G + 1, 0, 1'b0);
        abort = 1'b1;
        edge_step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_init", 32'(initialize), 32'd0);
        chk("abort_level", 32'(level), 32'd1);
        chk("abort_hp", 32'(init_hp), 32'(HPB));
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk("abort_start_busy", 32'(busy), 32'd0);
            chk("abort_start_init", 32'(initialize), 32'd0);
        end
        abort = 1'b0;
        kills = '0;
        enemy_dead = '0;
        edge_step();
        start = 1'b0;
        spawn_phase(1, T_ACTIVE, 0, 1'b1);
        kills = '0;
        kills[0] = 1'b1;
        kills[1] = 1'b1;
        enemy_dead = kills;
        #1;
        chk("pre_reset_alive", 32'(alive_count), 32'(N - 2));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_init", 32'(initialize), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_level", 32'(level), 32'd1);
        chk("async_rst_alive", 32'(alive_count), 32'd0);
        #2;
        reset = 1'b1;
        kills = '0;
        enemy_dead = '0;
        edge_step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        start_game();
        spawn_phase(1, 10, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
